p1_pool_engine: RTL and testbench
=================================

# p1_pool_engine

2×2 stride-2 max-pooling engine for layer 1. Reads the 24×24 conv-1 feature map from the C1 output RAM (synchronous, 1-cycle read latency). Produces the 144-entry 12×12 pooled map as a stream of single-word writes into the P1 output memory. Sits between the C1 output memory and the P1 write side; one run is started by a `start` pulse from the top-level sequencer.

## Interface
Parameters:
- DATA_W, 16, signed fixed-point word width
- IN_DIM, 24, input map side; output side is IN_DIM/2 = 12
- IN_AW, 10, C1 RAM address width
- OUT_AW, 8, P1 RAM address width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  run request, sampled only in IDLE/DONE
- rd_en  out  1  C1 RAM read strobe
- rd_addr  out  IN_AW  C1 RAM address
- rd_data  in  DATA_W  C1 RAM data, valid the cycle after rd_en
- wr_en  out  1  P1 RAM write strobe, one cycle per pooled value
- wr_addr  out  OUT_AW  P1 address, 0..143
- wr_data  out  DATA_W  pooled value
- busy  out  1  run in progress
- done  out  1  run complete, level

## Operation
- FSM states: IDLE, RD0, RD1, RD2, RD3, FIN, DONE.
- Transitions:
  - IDLE/DONE + start → RD0.
  - RD0→RD1→RD2→RD3→FIN.
  - FIN → RD0 if windows remain, else DONE.
  - DONE holds until start or reset.
- Window counters pr, pc in 0..11. Window k = 12·pr + pc.
  - Advance pc in FIN.
  - pc wraps 11→0 with pr+1.
  - pr=11, pc=11 is the last window.
- Read order, with base = 48·pr + 2·pc:
  - RD0: base
  - RD1: base+1
  - RD2: base+24
  - RD3: base+25
  - rd_en=1 only in RD0..RD3.
- Data capture:
  - RD1: max_r ← d0.
  - RD2 and RD3: max_r ← max(max_r, d).
  - FIN: result = max(max_r, d3).
  - Comparison is signed, two's complement. Ties keep either value; identical by value.
- At the FIN→next edge: wr_en←1, wr_addr←k, wr_data←result. wr_en deasserts the following cycle.
- start outside IDLE/DONE is ignored. A start in DONE clears done and reruns from window 0.
- rd_data outside the four capture cycles is ignored.
- Reset, at any time including mid-run:
  - All outputs 0.
  - FSM to IDLE, counters and max_r cleared.
  - No partial write is emitted after reset deasserts.

## Timing
- Outputs rd_en, rd_addr, wr_*, busy and done are driven from registers or state decode only; no input→output combinational path.
- Let E0 be the edge sampling start.
  - Window k reads occur in the cycles after E(5k)..E(5k+3).
  - Its write is visible in the cycle after E(5k+5).
- First write: wr_addr=0 in the cycle after E5. Last write: wr_addr=143 in the cycle after E720.
- busy: high from the cycle after E0 through the last wr_en cycle.
- done: high from the cycle after E721.
- Run length: 720 cycles start→last write; 576 reads; 144 writes.
- Per window: 5 cycles, no overlap between windows.

## Configuration
- P1_RELU_EN:
  - Defined: wr_data = (result < 0) ? 0 : result, i.e. ReLU is fused before the write.
  - Undefined: wr_data = result unmodified.
- Timing is identical in both builds.

## Structure
- Package p1_pkg:
  - DATA_W, IN_DIM, OUT_DIM, IN_AW, OUT_AW constants.
  - The FSM state enum.
  - Total window count 144.
- Sub-module p1_pool_addr_gen contains:
  - the pr/pc counters with wrap;
  - base and four-offset rd_addr generation;
  - window index k;
  - the last-window flag.
- The FSM and max datapath stay in p1_pool_engine.

## Test plan
- Ramp map, rd_data = address; start at E0:
  - wr_addr 0 = 25, wr_addr 1 = 27, wr_addr 12 = 73, wr_addr 143 = 575.
  - Exactly 144 writes.
  - done high from the cycle after E721.
- Last-window reads are 550, 551, 574, 575, in that order.
- All-negative map (every word −5, max word at base+24 = −1):
  - Without P1_RELU_EN, every wr_data = −1.
  - With P1_RELU_EN, every wr_data = 0.
- Single positive pixel 100 at address 575, rest 0: only wr_addr 143 = 100, all others 0.
- start pulsed repeatedly while busy: no restart, write sequence unchanged. start in DONE: done drops, a full 144-write run repeats.
- reset asserted mid-window, e.g. during RD2 of window 37:
  - All outputs 0 immediately.
  - No write for window 37.
  - A subsequent start restarts from wr_addr 0.

Source files
------------

// File: rtl/p1_pkg.sv
// Shared constants and FSM encoding for the layer-1 2x2 max-pooling engine.
package p1_pkg;

    localparam int DATA_W  = 16;
    localparam int IN_DIM  = 24;
    localparam int OUT_DIM = IN_DIM / 2;
    localparam int IN_AW   = 10;
    localparam int OUT_AW  = 8;
    localparam int N_WIN   = OUT_DIM * OUT_DIM;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        RD2  = 3'd3,
        RD3  = 3'd4,
        FIN  = 3'd5,
        DONE = 3'd6
    } state_t;

endpackage

// File: rtl/p1_pool_addr_gen.sv
// Window counters (pr, pc) and C1 read address / P1 write index generation.
// Addresses are pure decode of the counter registers and the offset select.
module p1_pool_addr_gen
    import p1_pkg::*;
#(
    parameter int IN_DIM = p1_pkg::IN_DIM,
    parameter int IN_AW  = p1_pkg::IN_AW,
    parameter int OUT_AW = p1_pkg::OUT_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    input  logic [1:0]        sel,
    output logic [IN_AW-1:0]  rd_addr,
    output logic [OUT_AW-1:0] k,
    output logic              last
);

    localparam int OD = IN_DIM / 2;
    localparam int CW = $clog2(OD);

    logic [CW-1:0] pr;
    logic [CW-1:0] pc;
    int            base;
    int            offset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pr <= '0;
            pc <= '0;
        end else if (clear) begin
            pr <= '0;
            pc <= '0;
        end else if (advance) begin
            if (pc == CW'(OD - 1)) begin
                pc <= '0;
                // Wrapping after the last window leaves the counters ready for a rerun.
                pr <= (pr == CW'(OD - 1)) ? '0 : pr + 1'b1;
            end else begin
                pc <= pc + 1'b1;
            end
        end
    end

    always_comb begin
        offset = 0;
        case (sel)
            2'd0: offset = 0;
            2'd1: offset = 1;
            2'd2: offset = IN_DIM;
            2'd3: offset = IN_DIM + 1;
            default: offset = 0;
        endcase
    end

    assign base    = 2 * IN_DIM * int'(pr) + 2 * int'(pc);
    assign rd_addr = IN_AW'(base + offset);
    assign k       = OUT_AW'(OD * int'(pr) + int'(pc));
    assign last    = (pr == CW'(OD - 1)) && (pc == CW'(OD - 1));

endmodule

// File: rtl/p1_pool_engine.sv
// 2x2 stride-2 max pool of the C1 map into P1: 5 cycles per window, one write each.
// Define P1_RELU_EN to clamp negative pooled values to zero before the write.
module p1_pool_engine
    import p1_pkg::*;
#(
    parameter int DATA_W = p1_pkg::DATA_W,
    parameter int IN_DIM = p1_pkg::IN_DIM,
    parameter int IN_AW  = p1_pkg::IN_AW,
    parameter int OUT_AW = p1_pkg::OUT_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              rd_en,
    output logic [IN_AW-1:0]  rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [OUT_AW-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    state_t state;
    state_t state_next;

    logic               accept;
    logic               advance;
    logic [1:0]         sel;
    logic [IN_AW-1:0]   addr_raw;
    logic [OUT_AW-1:0]  k;
    logic               last;

    logic signed [DATA_W-1:0] d;
    logic signed [DATA_W-1:0] max_r;
    logic signed [DATA_W-1:0] result;
    logic signed [DATA_W-1:0] wval;

    assign accept = start && ((state == IDLE) || (state == DONE));

    p1_pool_addr_gen #(
        .IN_DIM (IN_DIM),
        .IN_AW  (IN_AW),
        .OUT_AW (OUT_AW)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .advance (advance),
        .sel     (sel),
        .rd_addr (addr_raw),
        .k       (k),
        .last    (last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = RD0;
            RD0:        state_next = RD1;
            RD1:        state_next = RD2;
            RD2:        state_next = RD3;
            RD3:        state_next = FIN;
            FIN:        state_next = last ? DONE : RD0;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        rd_en   = 1'b0;
        sel     = 2'd0;
        advance = 1'b0;
        case (state)
            RD0: begin rd_en = 1'b1; sel = 2'd0; end
            RD1: begin rd_en = 1'b1; sel = 2'd1; end
            RD2: begin rd_en = 1'b1; sel = 2'd2; end
            RD3: begin rd_en = 1'b1; sel = 2'd3; end
            FIN: advance = 1'b1;
            default: ;
        endcase
        // The final write cycle lands while the FSM already sits in DONE.
        busy = ((state != IDLE) && (state != DONE)) || wr_en;
    end

    assign rd_addr = rd_en ? addr_raw : '0;

    // Data for the read issued in state RDn arrives in the following state.
    assign d      = rd_data;
    assign result = (d > max_r) ? d : max_r;

`ifdef P1_RELU_EN
    assign wval = result[DATA_W-1] ? '0 : result;
`else
    assign wval = result;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            max_r <= '0;
        end else begin
            case (state)
                RD1:      max_r <= d;
                RD2, RD3: max_r <= result;
                default:  max_r <= max_r;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done    <= 1'b0;
        end else begin
            wr_en <= (state == FIN);
            if (state == FIN) begin
                wr_addr <= k;
                wr_data <= wval;
            end
            done <= (state == DONE) && !start;
        end
    end

endmodule

// File: tb/tb_p1_pool_engine.sv
// Directed bench for p1_pool_engine: C1 RAM model, write capture, hand-computed expectations.
module tb_p1_pool_engine;
    import p1_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              rd_en;
    logic [IN_AW-1:0]  rd_addr;
    logic [DATA_W-1:0] rd_data = '0;
    logic              wr_en;
    logic [OUT_AW-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;

    p1_pool_engine dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [0:IN_DIM*IN_DIM-1];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    int n_cmp = 0;
    int n_err = 0;

    int wdat [N_WIN];
    int wcnt, first_cyc, first_addr, last_cyc, done_cyc, order_err, busy_err, done_at0;
    int rlog [4];
    int post_rst_wr;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " rd_en"},   rd_en,   0);
        check({tag, " rd_addr"}, rd_addr, 0);
        check({tag, " wr_en"},   wr_en,   0);
        check({tag, " wr_addr"}, wr_addr, 0);
        check({tag, " wr_data"}, wr_data, 0);
        check({tag, " busy"},    busy,    0);
        check({tag, " done"},    done,    0);
    endtask

    // Iteration n samples the cycle after edge E(n), E0 being the edge that sees start.
    task automatic run_map(input bit pulse_busy, input int rst_at);
        wcnt = 0; first_cyc = -1; first_addr = -1; last_cyc = -1; done_cyc = -1;
        order_err = 0; busy_err = 0; done_at0 = -1; post_rst_wr = 0;
        for (int i = 0; i < N_WIN; i++) wdat[i] = -9999;
        for (int i = 0; i < 4; i++) rlog[i] = -1;
        @(negedge clk);
        start = 1'b1;
        for (int n = 0; n < 760; n++) begin
            @(negedge clk);
            start = pulse_busy && (n >= 2) && (n < 700) && (n % 7 == 2);
            if (n == rst_at) begin
                reset = 1'b1;
                #1;
                check_idle_outputs("reset mid-run");
                repeat (3) @(negedge clk);
                reset = 1'b0;
                repeat (12) begin
                    @(negedge clk);
                    if (wr_en) post_rst_wr++;
                end
                return;
            end
            if (n == 0) done_at0 = done;
            if (wr_en) begin
                if (first_cyc < 0) begin
                    first_cyc  = n;
                    first_addr = wr_addr;
                end
                if (int'(wr_addr) != wcnt) order_err++;
                if (wr_addr < N_WIN) wdat[wr_addr] = $signed(wr_data);
                wcnt++;
                last_cyc = n;
            end
            if (rd_en) begin
                rlog[0] = rlog[1]; rlog[1] = rlog[2]; rlog[2] = rlog[3];
                rlog[3] = rd_addr;
            end
            if (busy != (n <= 720)) busy_err++;
            if (done && done_cyc < 0) done_cyc = n;
        end
    endtask

    function automatic int ramp_errors();
        int e = 0;
        for (int pr = 0; pr < OUT_DIM; pr++)
            for (int pc = 0; pc < OUT_DIM; pc++)
                if (wdat[pr*OUT_DIM+pc] != 48*pr + 2*pc + 25) e++;
        return e;
    endfunction

    task automatic check_timing(input string tag);
        check({tag, " write count"}, wcnt, 144);
        check({tag, " first write cycle"}, first_cyc, 5);
        check({tag, " first wr_addr"}, first_addr, 0);
        check({tag, " last write cycle"}, last_cyc, 720);
        check({tag, " done first cycle"}, done_cyc, 721);
        check({tag, " wr_addr order errors"}, order_err, 0);
        check({tag, " busy errors"}, busy_err, 0);
    endtask

    initial begin
        int neg_exp;
        int errs;

        repeat (3) @(negedge clk);
        check_idle_outputs("in reset");
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("after reset");

        for (int i = 0; i < IN_DIM*IN_DIM; i++) mem[i] = DATA_W'(i);
        run_map(1'b0, -1);
        check_timing("ramp");
        check("ramp w0", wdat[0], 25);
        check("ramp w1", wdat[1], 27);
        check("ramp w12", wdat[12], 73);
        check("ramp w143", wdat[143], 575);
        check("ramp all windows errors", ramp_errors(), 0);
        check("last window read 0", rlog[0], 550);
        check("last window read 1", rlog[1], 551);
        check("last window read 2", rlog[2], 574);
        check("last window read 3", rlog[3], 575);
        check("done holds", done, 1);

        run_map(1'b1, -1);
        check("rerun done cleared by start", done_at0, 0);
        check_timing("rerun with busy starts");
        check("rerun ramp errors", ramp_errors(), 0);

        for (int i = 0; i < IN_DIM*IN_DIM; i++)
            mem[i] = (((i / IN_DIM) % 2 == 1) && ((i % IN_DIM) % 2 == 0)) ? -16'sd1 : -16'sd5;
`ifdef P1_RELU_EN
        neg_exp = 0;
`else
        neg_exp = -1;
`endif
        run_map(1'b0, -1);
        errs = 0;
        for (int i = 0; i < N_WIN; i++) if (wdat[i] != neg_exp) errs++;
        check("neg w0", wdat[0], neg_exp);
        check("neg w77", wdat[77], neg_exp);
        check("neg all windows errors", errs, 0);
        check("neg write count", wcnt, 144);

        for (int i = 0; i < IN_DIM*IN_DIM; i++) mem[i] = '0;
        mem[575] = 16'd100;
        run_map(1'b0, -1);
        errs = 0;
        for (int i = 0; i < N_WIN - 1; i++) if (wdat[i] != 0) errs++;
        check("pixel w143", wdat[143], 100);
        check("pixel other nonzero", errs, 0);

        for (int i = 0; i < IN_DIM*IN_DIM; i++) mem[i] = DATA_W'(i);
        run_map(1'b0, 187);
        check("reset run writes before reset", wcnt, 37);
        check("reset run last addr", wdat[36], 48*3 + 2*0 + 25);
        check("reset run window 37 absent", wdat[37], -9999);
        check("writes after reset", post_rst_wr, 0);
        run_map(1'b0, -1);
        check_timing("after reset");
        check("after reset ramp errors", ramp_errors(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
